// File: rtl/cmd_engine.sv
// cmd_engine: assembles 64-bit host frames from the RX FIFO and runs them.
// Loopback command compiled in only when CMD_ENGINE_LOOPBACK_EN is defined.
module cmd_engine #(
  parameter int DATA_W = 8,
  parameter int GPIO_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              rxfifo_empty,
  output logic              rxfifo_rd,
  input  logic              rxfifo_valid,
  input  logic [DATA_W-1:0] rxfifo_data,
  input  logic              txfifo_full,
  output logic              txfifo_wr,
  output logic [DATA_W-1:0] txfifo_data,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              busy
);
  localparam int FRAME_WORDS = 64 / DATA_W;
  localparam int FILL_W = $clog2(FRAME_WORDS + 1);
  localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FRAME_WORDS);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_WORDS - 1);
  localparam logic [15:0] CODE_PAT  = 16'hBEEF;
  localparam logic [15:0] CODE_GPIO = 16'h1ED0;
  localparam logic [15:0] CODE_STAT = 16'h57A7;
`ifdef CMD_ENGINE_LOOPBACK_EN
  localparam logic [15:0] CODE_LOOP = 16'hC0DE;
`endif

  typedef enum logic [2:0] {
    CMD_WAIT_S,
    CMD_READ_S,
    CMD_PARSE_S,
    TX_PATTERN_S,
    TX_STATUS_S
`ifdef CMD_ENGINE_LOOPBACK_EN
    , LOOP_WAIT_S,
    LOOP_READ_S,
    LOOP_WRITE_S
`endif
  } state_t;

  state_t state, state_nxt;

  logic [63:0] shifter, shift_in, status;
  logic [FILL_W-1:0] fill_cnt;
  logic [IDX_W-1:0] tx_idx;
  logic [15:0] slip_cnt, unk_cnt, code;
  logic [CNT_W-1:0] word_cnt;
  logic [DATA_W-1:0] pattern, tx_data;
  logic rd, wr, frame_ok, accept;

  generate
    if (DATA_W == 64) begin : g_whole
      assign shift_in = rxfifo_data;
    end else begin : g_part
      assign shift_in = {rxfifo_data, shifter[63:DATA_W]};
    end
  endgenerate

  assign frame_ok = (shifter[63:56] == 8'hAA) && (shifter[7:0] == 8'h55);
  assign code = shifter[55:40];
  assign accept = wr && !txfifo_full;
  // strobes are held low while reset is asserted
  assign rxfifo_rd = rd && sys_rst_n;
  assign txfifo_wr = wr && sys_rst_n;
  assign txfifo_data = tx_data;
  assign busy = (state != CMD_WAIT_S);

  // state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= CMD_WAIT_S;
    else state <= state_nxt;
  end

  // next-state, FIFO strobes and TX data mux
  always_comb begin
    state_nxt = state;
    rd = 1'b0;
    wr = 1'b0;
    tx_data = '0;
    unique case (state)
      CMD_WAIT_S: begin
        if (!rxfifo_empty) begin
          rd = 1'b1;
          state_nxt = CMD_READ_S;
        end
      end
      CMD_READ_S: begin
        if (rxfifo_valid)
          state_nxt = (fill_cnt >= FILL_LAST) ? CMD_PARSE_S : CMD_WAIT_S;
      end
      CMD_PARSE_S: begin
        state_nxt = CMD_WAIT_S;
        if (frame_ok) begin
          if (code == CODE_PAT) state_nxt = TX_PATTERN_S;
          else if (code == CODE_STAT) state_nxt = TX_STATUS_S;
`ifdef CMD_ENGINE_LOOPBACK_EN
          else if (code == CODE_LOOP) state_nxt = LOOP_WAIT_S;
`endif
        end
      end
      TX_PATTERN_S: begin
        if (word_cnt == '0) begin
          state_nxt = CMD_WAIT_S;
        end else begin
          wr = 1'b1;
          tx_data = pattern;
        end
      end
      TX_STATUS_S: begin
        wr = 1'b1;
        tx_data = status[DATA_W-1:0];
        if (!txfifo_full && tx_idx == IDX_LAST) state_nxt = CMD_WAIT_S;
      end
`ifdef CMD_ENGINE_LOOPBACK_EN
      LOOP_WAIT_S: begin
        if (word_cnt == '0) begin
          state_nxt = CMD_WAIT_S;
        end else if (!rxfifo_empty) begin
          rd = 1'b1;
          state_nxt = LOOP_READ_S;
        end
      end
      LOOP_READ_S: begin
        if (rxfifo_valid) state_nxt = LOOP_WRITE_S;
      end
      LOOP_WRITE_S: begin
        wr = 1'b1;
        tx_data = pattern;
        if (!txfifo_full) state_nxt = LOOP_WAIT_S;
      end
`endif
      default: state_nxt = CMD_WAIT_S;
    endcase
  end

  // frame assembly, command execution and stream counters
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      shifter <= '0;
      fill_cnt <= '0;
      slip_cnt <= '0;
      unk_cnt <= '0;
      word_cnt <= '0;
      pattern <= '0;
      status <= '0;
      tx_idx <= '0;
      gpio_out <= '0;
    end else begin
      case (state)
        CMD_READ_S: begin
          if (rxfifo_valid) begin
            shifter <= shift_in;
            if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + 1'b1;
          end
        end
        CMD_PARSE_S: begin
          if (!frame_ok) begin
            if (slip_cnt != 16'hFFFF) slip_cnt <= slip_cnt + 1'b1;
          end else begin
            shifter <= '0;
            fill_cnt <= '0;
            if (code == CODE_PAT) begin
              word_cnt <= shifter[8 +: CNT_W];
              pattern <= '0;
            end else if (code == CODE_GPIO) begin
              gpio_out <= shifter[8 +: GPIO_W];
            end else if (code == CODE_STAT) begin
              status <= {8'hAA, CODE_STAT, slip_cnt, unk_cnt, 8'h55};
              tx_idx <= '0;
            end
`ifdef CMD_ENGINE_LOOPBACK_EN
            else if (code == CODE_LOOP) begin
              word_cnt <= shifter[8 +: CNT_W];
            end
`endif
            else if (unk_cnt != 16'hFFFF) begin
              unk_cnt <= unk_cnt + 1'b1;
            end
          end
        end
        TX_PATTERN_S: begin
          if (accept) begin
            pattern <= pattern + 1'b1;
            word_cnt <= word_cnt - 1'b1;
          end
        end
        TX_STATUS_S: begin
          if (accept) begin
            status <= status >> DATA_W;
            tx_idx <= tx_idx + 1'b1;
          end
        end
`ifdef CMD_ENGINE_LOOPBACK_EN
        LOOP_READ_S: begin
          if (rxfifo_valid) pattern <= rxfifo_data;
        end
        LOOP_WRITE_S: begin
          if (accept) word_cnt <= word_cnt - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_engine.sv
// tb_cmd_engine: scoreboard bench for cmd_engine with DATA_W=8.
// Loopback expectations follow CMD_ENGINE_LOOPBACK_EN.
module tb_cmd_engine;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic rxfifo_empty = 1'b1;
  logic rxfifo_rd;
  logic rxfifo_valid = 1'b0;
  logic [7:0] rxfifo_data = 8'h00;
  logic txfifo_full = 1'b0;
  logic txfifo_wr;
  logic [7:0] txfifo_data;
  logic [9:0] gpio_out;
  logic busy;

  cmd_engine #(.DATA_W(8), .GPIO_W(10), .CNT_W(32)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .rxfifo_empty(rxfifo_empty),
    .rxfifo_rd(rxfifo_rd),
    .rxfifo_valid(rxfifo_valid),
    .rxfifo_data(rxfifo_data),
    .txfifo_full(txfifo_full),
    .txfifo_wr(txfifo_wr),
    .txfifo_data(txfifo_data),
    .gpio_out(gpio_out),
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] rx_q[$];
  logic [7:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int first_acc = 0;
  int last_acc = 0;
  int last_valid = 0;
  int snap = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RX FIFO model: data and valid one cycle after the read strobe
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    rxfifo_valid <= 1'b0;
    if (rxfifo_rd && rx_q.size() > 0) begin
      rxfifo_data <= rx_q.pop_front();
      rxfifo_valid <= 1'b1;
    end
  end

  // TX monitor: scoreboard compare, hold-while-full check, timing marks
  always @(negedge sys_clk) begin
    rxfifo_empty = (rx_q.size() == 0);
    if (rxfifo_valid) last_valid = cyc;
    if (prev_stall) begin
      check("hold_wr", txfifo_wr, 1);
      check("hold_data", txfifo_data, prev_data);
    end
    prev_stall = txfifo_wr && txfifo_full;
    prev_data = txfifo_data;
    if (txfifo_wr && !txfifo_full) begin
      if (acc_cnt == 0) first_acc = cyc;
      last_acc = cyc;
      acc_cnt++;
      check("tx_expected", sb.size() != 0, 1);
      if (sb.size() != 0) check("tx_data", txfifo_data, sb.pop_front());
    end
  end

  task automatic send_frame(logic [15:0] code, logic [31:0] data);
    logic [63:0] f;
    f = {8'hAA, code, data, 8'h55};
    for (int k = 0; k < 8; k++) rx_q.push_back(f[k*8 +: 8]);
  endtask

  task automatic expect_status(logic [15:0] slip, logic [15:0] unk);
    logic [63:0] f;
    f = {8'hAA, 16'h57A7, slip, unk, 8'h55};
    for (int k = 0; k < 8; k++) sb.push_back(f[k*8 +: 8]);
    send_frame(16'h57A7, 32'h0);
  endtask

  task automatic wait_idle(string tag);
    int idle;
    int i;
    idle = 0;
    i = 0;
    while (i < 4000 && idle < 4) begin
      @(negedge sys_clk);
      i++;
      if (!busy && rx_q.size() == 0 && sb.size() == 0 && !rxfifo_valid)
        idle++;
      else
        idle = 0;
    end
    check({tag, "_done"}, idle >= 4, 1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_rd"}, rxfifo_rd, 0);
    check({tag, "_wr"}, txfifo_wr, 0);
    check({tag, "_data"}, txfifo_data, 0);
    check({tag, "_gpio"}, gpio_out, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_outputs("rst");
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // pattern of 10 with no backpressure
    for (int i = 0; i < 10; i++) sb.push_back(8'(i));
    acc_cnt = 0;
    send_frame(16'hBEEF, 32'd10);
    wait_idle("pat10");
    check("pat10_count", acc_cnt, 10);
    check("pat10_span", last_acc - first_acc, 9);
    check("pat10_latency", first_acc - last_valid, 2);
    check("pat10_busy", busy, 0);

    // same pattern with 5 cycles of full mid-stream
    for (int i = 0; i < 10; i++) sb.push_back(8'(i));
    acc_cnt = 0;
    send_frame(16'hBEEF, 32'd10);
    for (int i = 0; i < 300 && acc_cnt < 3; i++) @(negedge sys_clk);
    @(posedge sys_clk);
    #1 txfifo_full = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1 txfifo_full = 1'b0;
    wait_idle("patbp");
    check("patbp_count", acc_cnt, 10);

    // zero-count pattern writes nothing
    acc_cnt = 0;
    send_frame(16'hBEEF, 32'd0);
    wait_idle("pat0");
    check("pat0_count", acc_cnt, 0);

    // GPIO write then status
    acc_cnt = 0;
    send_frame(16'h1ED0, 32'h2A5);
    wait_idle("gpio");
    check("gpio_val", gpio_out, 10'h2A5);
    check("gpio_no_tx", acc_cnt, 0);
    expect_status(16'd0, 16'd0);
    wait_idle("stat0");

    // stray byte forces one slip, frame still executes
    rx_q.push_back(8'h12);
    send_frame(16'h1ED0, 32'h155);
    wait_idle("slip");
    check("slip_gpio", gpio_out, 10'h155);
    send_frame(16'h1234, 32'h0);
    wait_idle("unk");
    acc_cnt = 0;
    expect_status(16'd1, 16'd1);
    wait_idle("stat1");
    check("stat1_count", acc_cnt, 8);

`ifdef CMD_ENGINE_LOOPBACK_EN
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    send_frame(16'hC0DE, 32'd3);
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    rx_q.push_back(8'h33);
    wait_idle("loop");
    expect_status(16'd1, 16'd1);
    wait_idle("stat_loop");
`else
    // unknown code; following bytes become partial frame, causing 3 slips
    send_frame(16'hC0DE, 32'd3);
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    rx_q.push_back(8'h33);
    wait_idle("noloop");
    expect_status(16'd4, 16'd2);
    wait_idle("stat_noloop");
`endif

    // reset in the middle of a long pattern
    for (int i = 0; i < 1000; i++) sb.push_back(8'(i));
    acc_cnt = 0;
    send_frame(16'hBEEF, 32'd1000);
    for (int i = 0; i < 300 && acc_cnt < 20; i++) @(negedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_outputs("midrst");
    sb.delete();
    snap = acc_cnt;
    repeat (20) @(negedge sys_clk);
    check("midrst_no_tx", acc_cnt, snap);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    expect_status(16'd0, 16'd0);
    wait_idle("stat_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
